digest_reader: RTL

Read-side companion to the hash-state accumulators (H0..H7). After the final message block has been folded into the hash state, it captures all eight 32-bit words in one cycle and streams them out as eight 32-bit beats over a valid/ready handshake. It also produces a one-cycle difficulty verdict (leading-zero test) so the miner control can stop early on a hit.

---
 rtl/digest_reader.sv | 113 +++++++++++
 1 files changed

// File: rtl/digest_reader.sv
// Captures the eight final hash words on load, streams them out as eight
// valid/ready beats (H0 first) and flags a leading-zero difficulty hit.
module digest_reader #(
  parameter int unsigned DIFF_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] H0,
  input  logic [31:0] H1,
  input  logic [31:0] H2,
  input  logic [31:0] H3,
  input  logic [31:0] H4,
  input  logic [31:0] H5,
  input  logic [31:0] H6,
  input  logic [31:0] H7,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        hit_valid,
  output logic        hit,
  output logic        overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [9:0] DIFF_W = 10'(DIFF_BITS);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] buf_q [8];
  logic [31:0] buf_d [8];
  logic        hit_q, hit_d;
  logic        hit_valid_q, hit_valid_d;
  logic        overrun_q, overrun_d;

  logic [255:0] digest;
  logic [8:0]   lz;
  logic         hit_now;
  logic         handshake;
  logic         last_beat;
  logic         accept;

  assign digest = {H0, H1, H2, H3, H4, H5, H6, H7};

  // Priority encoder: the highest set bit wins because it is visited last.
  always_comb begin
    lz = 9'd256;
    for (int i = 0; i < 256; i++) begin
      if (digest[i]) lz = 9'(255 - i);
    end
  end

  assign hit_now = ({1'b0, lz} >= DIFF_W);

  assign handshake = (state_q == SEND) && out_ready;
  assign last_beat = handshake && (idx_q == 3'd7);
  // A load coinciding with the final handshake starts the next digest with no bubble.
  assign accept    = load && ((state_q == IDLE) || last_beat);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    hit_d       = hit_q;
    hit_valid_d = accept;
    overrun_d   = overrun_q;

    if (handshake) idx_d = idx_q + 3'd1;
    if (last_beat) state_d = IDLE;

    if (accept) begin
      buf_d   = '{H0, H1, H2, H3, H4, H5, H6, H7};
      state_d = SEND;
      idx_d   = 3'd0;
      hit_d   = hit_now;
    end else if (load) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      hit_q       <= 1'b0;
      hit_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      hit_valid_q <= hit_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Buffer contents are irrelevant after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign out_valid = (state_q == SEND);
  assign busy      = out_valid;
  assign out_last  = out_valid && (idx_q == 3'd7);
  assign out_data  = out_valid ? buf_q[idx_q] : 32'd0;
  assign hit       = hit_q;
  assign hit_valid = hit_valid_q;
  assign overrun   = overrun_q;

endmodule
